demux_dispatcher: RTL and testbench
===================================

DEMUX_DISPATCHER -- requirements
Module: demux_dispatcher

Interface
REQ-001 Parameter DATA_W, default 8, width of the routed data word.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream word available.
REQ-005 in_data  input  DATA_W  upstream word.
REQ-006 in_ready  output  1  dispatcher accepts in_data this cycle.
REQ-007 chan_en  input  4  per-channel enable mask; bit i set means channel i may receive words.
REQ-008 out_valid  output  4  one-hot-or-zero; bit i means out_data is valid for channel i.
REQ-009 out_data  output  DATA_W  shared output data bus, meaningful only while any out_valid bit is set.
REQ-010 out_ready  input  4  per-channel downstream ready.
REQ-011 sel  output  2  index of the channel currently targeted by the held word; 0 when empty.
REQ-012 xfer_cnt  output  8  count of completed output transfers.

Function
REQ-013 The block SHALL hold at most one word in a single output register with its target index; states EMPTY and HOLD.
REQ-014 An input transfer SHALL occur when in_valid and in_ready are both 1; an output transfer SHALL occur when out_valid[sel] and out_ready[sel] are both 1.
REQ-015 in_ready SHALL be 1 when chan_en != 0 and either the state is EMPTY or an output transfer occurs in the same cycle; otherwise 0.
REQ-016 in_ready SHALL depend combinationally on out_ready[sel]; out_valid, out_data and sel SHALL come directly from registers.
REQ-017 On an input transfer, the target SHALL be the first set bit of chan_en, searching cyclically from (last_served+1) mod 4. The search SHALL use chan_en sampled in that cycle.
REQ-018 last_served SHALL update to the delivered channel index on each output transfer.
REQ-019 When an output transfer and an input transfer occur in the same cycle, the new target SHALL be computed from the index just delivered. The state SHALL stay HOLD with no bubble, giving one word per cycle of throughput.
REQ-020 Transitions:
  - EMPTY -> HOLD on an input transfer.
  - HOLD -> EMPTY on an output transfer without an input transfer.
  - HOLD -> HOLD in all other cases.
REQ-021 Latency SHALL be one cycle: a word accepted in cycle N SHALL be presented on out_valid/out_data in cycle N+1.
REQ-022 While in HOLD, out_valid[sel], out_data and sel SHALL remain stable until the output transfer. Changes to chan_en SHALL NOT retarget or drop the held word, even if its channel is disabled.
REQ-023 When chan_en == 0, no input transfer SHALL occur. A word already held SHALL still be delivered.
REQ-024 out_ready bits of non-targeted channels SHALL have no effect.
REQ-025 xfer_cnt SHALL increment by 1 per output transfer and wrap from 255 to 0.
REQ-026 Words SHALL never be duplicated, lost or reordered.

Reset
REQ-027 Asserting rstn low SHALL immediately clear all of the following, including mid-transfer; any held word is discarded:
  - state to EMPTY;
  - out_valid to 0, out_data to 0, sel to 0, xfer_cnt to 0;
  - last_served to 3, so the first word goes to the lowest enabled channel at or above 0.
REQ-028 Deassertion SHALL be synchronised externally. The block SHALL accept input in the first clock after rstn rises.

Structure
REQ-029 A shared package SHALL hold:
  - the state enumeration (EMPTY, HOLD);
  - channel count constant NUM_CH = 4;
  - index width constant CH_W = 2.
REQ-030 The round-robin search SHALL live in one purely combinational sub-module, rr_pick4. Its inputs are a 4-bit mask and a 2-bit start index; its outputs are a 2-bit index and a found flag.

Verification
REQ-031 Reset, then chan_en=4'b1111 and all out_ready=1. Stream in_data 0x10,0x11,0x12,0x13,0x14 back-to-back -> out_valid sequence 0001,0010,0100,1000,0001, one per cycle, 1-cycle latency, xfer_cnt=5.
REQ-032 chan_en=4'b1010, five words -> targets 1,3,1,3,1.
REQ-033 Word 0xAA held for channel 2 with out_ready[2]=0 for 4 cycles, out_ready[0]=1 meanwhile:
  - expected: in_ready=0, out_valid=0100 stable, out_data=0xAA stable;
  - then out_ready[2]=1 -> delivered, and the next word is accepted in the same cycle.
REQ-034 Hold a word for channel 1, then set chan_en=0 -> word still delivered on channel 1, after which in_ready=0 while in_valid=1.
REQ-035 Perform 256 transfers -> xfer_cnt wraps to 0. Pull rstn low while in HOLD -> out_valid=0, sel=0 immediately. After release, the first word goes to channel 0.

Source files
------------

// File: rtl/demux_dispatcher_pkg.sv
// Shared types and constants for the 1-to-4 round-robin demux dispatcher.
package demux_dispatcher_pkg;

  typedef enum logic {EMPTY, HOLD} state_t;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] idx);
    return NUM_CH'(1) << idx;
  endfunction

endpackage

// File: rtl/demux_dispatcher_if.sv
// Upstream/downstream handshake bundle of the demux dispatcher.
interface demux_dispatcher_if
  import demux_dispatcher_pkg::*;
#(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [NUM_CH-1:0] chan_en;
  logic [NUM_CH-1:0] out_valid;
  logic [DATA_W-1:0] out_data;
  logic [NUM_CH-1:0] out_ready;
  logic [CH_W-1:0]   sel;
  logic [7:0]        xfer_cnt;

  modport master (
    output in_valid, in_data, chan_en, out_ready,
    input  in_ready, out_valid, out_data, sel, xfer_cnt
  );

  modport slave (
    input  in_valid, in_data, chan_en, out_ready,
    output in_ready, out_valid, out_data, sel, xfer_cnt
  );
endinterface

// File: rtl/demux_dispatcher_rr_pick4.sv
// Combinational round-robin picker: first set mask bit at or after start, wrapping.
module rr_pick4
  import demux_dispatcher_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   start,
  output logic [CH_W-1:0]   idx,
  output logic              found
);

  logic [CH_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest enabled channel wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = start + CH_W'(k);
      if (mask[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_dispatcher.sv
// Single-register round-robin dispatcher: one word held, routed to one of four channels.
module demux_dispatcher
  import demux_dispatcher_pkg::*;
#(
  parameter int DATA_W = 8
)(
  input  logic                 clk,
  input  logic                 rstn,
  demux_dispatcher_if.slave    bus
);

  state_t            state;
  logic [DATA_W-1:0] data_p1;
  logic [NUM_CH-1:0] vld_p1;
  logic [CH_W-1:0]   sel_p1;
  logic [CH_W-1:0]   last_served;
  logic [7:0]        cnt_p1;

  logic              out_xfer;
  logic              in_xfer;
  logic              any_en;
  logic [CH_W-1:0]   start;
  logic [CH_W-1:0]   pick;

  assign out_xfer = (state == HOLD) && bus.out_ready[sel_p1];
  // A same-cycle delivery makes the delivered index the new round-robin origin.
  assign start    = (out_xfer ? sel_p1 : last_served) + CH_W'(1);

  rr_pick4 u_pick (
    .mask  (bus.chan_en),
    .start (start),
    .idx   (pick),
    .found (any_en)
  );

  assign bus.in_ready = any_en && ((state == EMPTY) || out_xfer);
  assign in_xfer      = bus.in_valid && bus.in_ready;

  // Stage p1: held word, its one-hot valid and target index.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= EMPTY;
      data_p1     <= '0;
      vld_p1      <= '0;
      sel_p1      <= '0;
      last_served <= CH_W'(NUM_CH - 1);
      cnt_p1      <= '0;
    end else begin
      if (out_xfer) begin
        last_served <= sel_p1;
        cnt_p1      <= cnt_p1 + 8'd1;
      end
      if (in_xfer) begin
        state   <= HOLD;
        data_p1 <= bus.in_data;
        sel_p1  <= pick;
        vld_p1  <= ch_onehot(pick);
      end else if (out_xfer) begin
        state  <= EMPTY;
        vld_p1 <= '0;
        sel_p1 <= '0;
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.sel       = sel_p1;
  assign bus.xfer_cnt  = cnt_p1;

endmodule

// File: tb/tb_demux_dispatcher.sv
// Bench for demux_dispatcher: directed scenarios plus random traffic against a word-level model.
module tb_demux_dispatcher;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  demux_dispatcher_if #(.DATA_W(8)) bus();

  demux_dispatcher #(.DATA_W(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: at most one held word, its channel, last served channel, transfer count.
  bit         m_held;
  logic [7:0] m_data;
  int         m_ch;
  int         m_last;
  int         m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic int rr_target(input logic [3:0] en, input int from);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (from + k) % 4;
      if (en[c]) return c;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_held = 1'b0;
    m_data = '0;
    m_ch   = 0;
    m_last = 3;
    m_cnt  = 0;
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic [3:0] exp_ov;
    bit         exp_rdy;
    bit         out_x;
    bit         in_x;
    @(negedge clk);
    exp_ov  = m_held ? 4'(1 << m_ch) : 4'd0;
    exp_rdy = (bus.chan_en != 0) && (!m_held || bus.out_ready[m_ch]);
    chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    chk("sel",       32'(bus.sel),       m_held ? 32'(m_ch) : 32'd0);
    chk("in_ready",  32'(bus.in_ready),  32'(exp_rdy));
    chk("xfer_cnt",  32'(bus.xfer_cnt),  32'(m_cnt));
    if (m_held) chk("out_data", 32'(bus.out_data), 32'(m_data));
    out_x = m_held && bus.out_ready[m_ch];
    in_x  = bus.in_valid && exp_rdy;
    @(posedge clk);
    if (out_x) begin
      m_last = m_ch;
      m_cnt  = (m_cnt + 1) % 256;
      m_held = 1'b0;
    end
    if (in_x) begin
      m_held = 1'b1;
      m_data = bus.in_data;
      m_ch   = rr_target(bus.chan_en, (m_last + 1) % 4);
    end
    #1;
  endtask

  // Asynchronous assertion checked right away, release away from the clock edge.
  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sel",       32'(bus.sel),       32'd0);
    chk("rst_xfer_cnt",  32'(bus.xfer_cnt),  32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  logic [3:0] exp_a [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int         exp_b [5] = '{1, 3, 1, 3, 1};

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.chan_en   = 4'b1111;
    bus.out_ready = 4'b1111;
    model_reset();
    #2;
    do_reset();

    // Back-to-back stream over all channels.
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h10 + 8'(i);
      step();
      chk("s1_valid", 32'(bus.out_valid), 32'(exp_a[i]));
      chk("s1_data",  32'(bus.out_data),  32'h10 + 32'(i));
    end
    bus.in_valid = 1'b0;
    step();
    chk("s1_cnt", 32'(bus.xfer_cnt), 32'd5);

    // Sparse mask alternates between channels 1 and 3.
    bus.chan_en = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h20 + 8'(i);
      step();
      chk("s2_sel", 32'(bus.sel), 32'(exp_b[i]));
    end
    bus.in_valid = 1'b0;
    step();

    // Stall on channel 2 while an untargeted channel is ready.
    bus.chan_en   = 4'b0100;
    bus.out_ready = 4'b0001;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hAA;
    step();
    bus.in_data = 8'hBB;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("s3_in_ready", 32'(bus.in_ready), 32'd0);
      step();
      chk("s3_valid", 32'(bus.out_valid), 32'b0100);
      chk("s3_data",  32'(bus.out_data),  32'hAA);
    end
    bus.out_ready = 4'b0101;
    #1;
    chk("s3_accept", 32'(bus.in_ready), 32'd1);
    step();
    chk("s3_next", 32'(bus.out_data), 32'hBB);
    bus.in_valid = 1'b0;
    step();

    // Disable every channel while a word is held for channel 1.
    bus.chan_en   = 4'b0010;
    bus.out_ready = 4'b0000;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h55;
    step();
    bus.chan_en   = 4'b0000;
    bus.in_data   = 8'h66;
    bus.out_ready = 4'b1111;
    step();
    chk("s4_drained", 32'(bus.out_valid), 32'd0);
    #1;
    chk("s4_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    chk("s4_empty", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b0;

    // 256 transfers wrap the counter.
    do_reset();
    bus.chan_en   = 4'b1111;
    bus.out_ready = 4'b1111;
    for (int i = 0; i < 256; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      step();
    end
    chk("s5_cnt255", 32'(bus.xfer_cnt), 32'd255);
    bus.in_valid = 1'b0;
    step();
    chk("s5_wrap", 32'(bus.xfer_cnt), 32'd0);

    // Reset while holding a word for channel 2; first word afterwards goes to channel 0.
    bus.chan_en   = 4'b0100;
    bus.out_ready = 4'b0000;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h3C;
    step();
    chk("s5_hold_sel", 32'(bus.sel), 32'd2);
    bus.in_valid = 1'b0;
    do_reset();
    bus.chan_en   = 4'b1111;
    bus.out_ready = 4'b1111;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h77;
    step();
    chk("s5_post_valid", 32'(bus.out_valid), 32'b0001);
    chk("s5_post_data",  32'(bus.out_data),  32'h77);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = 8'($urandom);
      bus.chan_en   = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
      bus.out_ready = 4'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
